// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and counter constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_e;

   localparam int CNT_W           = 16;
   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a per-transfer ack timeout and a saturating stall counter.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic              err_o
);

   arb_state_e        state_d, state_q;
   logic              last_dm_d, last_dm_q;
   logic              mem_req_d, mem_req_q;
   logic              mem_we_d, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_d, dm_rdata_q;
   logic              if_ready_d, if_ready_q;
   logic              dm_ready_d, dm_ready_q;
   logic              err_d, err_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              busy, timeout_hit, wait_inc, wait_clr;
   logic              if_elig, dm_elig;

   // A requester whose ready pulse is showing has just been served and must not re-grant.
   assign if_elig     = if_req_i && !if_ready_q;
   assign dm_elig     = dm_req_i && !dm_ready_q;
   assign busy        = (state_q != IDLE);
   assign timeout_hit = busy && !mem_ack_i && (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign wait_inc    = busy && !mem_ack_i && !timeout_hit;
   assign wait_clr    = !busy || mem_ack_i || timeout_hit;

   assign stall_o = (if_req_i && !if_ready_q) || (dm_req_i && !dm_ready_q);

   sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (wait_inc),
      .clr_i   (wait_clr),
      .count_o (wait_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall_o),
      .clr_i   (1'b0),
      .count_o (stall_cnt_o)
   );

   always_comb begin
      state_d     = state_q;
      last_dm_d   = last_dm_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            // DM wins a tie unless it was the last one served.
            if (dm_elig && (!if_elig || !last_dm_q)) begin
               state_d     = BUSY_DM;
               last_dm_d   = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
            end else if (if_elig) begin
               state_d     = BUSY_IF;
               last_dm_d   = 1'b0;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = '0;
            end
         end
         BUSY_IF: begin
            if (mem_ack_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_rdata_d = mem_rdata_i;
               if_ready_d = 1'b1;
            end else if (timeout_hit) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_rdata_d = '0;
               if_ready_d = 1'b1;
               err_d      = 1'b1;
            end
         end
         BUSY_DM: begin
            if (mem_ack_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_ready_d = 1'b1;
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
            end else if (timeout_hit) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_rdata_d = '0;
               dm_ready_d = 1'b1;
               err_d      = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         last_dm_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dm_q   <= last_dm_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         err_q       <= err_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign dm_ready_o  = dm_ready_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder with programmable ack delay,
// per-requester read-data queues and a queue of expected memory-port grants.
module tb_mem_arbiter;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 4;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
   } dm_exp_t;

   logic              clk_i;
   logic              rst_i;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_ready_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              dm_ready_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;
   logic              stall_o;
   logic [15:0]       stall_cnt_o;
   logic              err_o;

   logic [31:0] ifQ[$];
   dm_exp_t     dmQ[$];
   grant_t      grantQ[$];

   int   testCount   = 0;
   int   failCount   = 0;
   int   cycleCount  = 0;
   int   ackDelay    = 0;
   int   lastBusyLen = 0;
   bit   sbEnable    = 1'b1;
   bit   strayAck    = 1'b0;

   logic [31:0] lastIf, lastDm;
   dm_exp_t     monDm;
   logic [31:0] monIf;

   mem_arbiter #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_ready_o  (if_ready_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_rdata_o  (dm_rdata_o),
      .dm_ready_o  (dm_ready_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .stall_o     (stall_o),
      .stall_cnt_o (stall_cnt_o),
      .err_o       (err_o)
   );

   // Free-running clock and a cycle counter used to timestamp ready pulses.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cycleCount++;

   // Hard stop in case something wedges the run.
   initial begin
      #10000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] memData(input logic [31:0] addr);
      return 32'h8C01_0000 ^ ((addr - 32'h10) << 4);
   endfunction

   task automatic pushGrant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      grant_t g;
      g.we    = we;
      g.addr  = addr;
      g.wdata = wdata;
      grantQ.push_back(g);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Memory model: acks on BUSY cycle ackDelay+1 (never when negative), checks grants and
   // that the memory port holds steady while the request is up.
   initial begin : responder
      int     busy;
      grant_t g;
      grant_t cur;
      busy        = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (mem_req_o) begin
            busy++;
            if (busy == 1) begin
               cur.we    = mem_we_o;
               cur.addr  = mem_addr_o;
               cur.wdata = mem_wdata_o;
               if (sbEnable) begin
                  if (grantQ.size() == 0) begin
                     checkOutput("grant_unexpected", 32'(mem_req_o), 0);
                  end else begin
                     g = grantQ.pop_front();
                     checkOutput("grant_we", 32'(mem_we_o), 32'(g.we));
                     checkOutput("grant_addr", mem_addr_o, g.addr);
                     if (g.we) checkOutput("grant_wdata", mem_wdata_o, g.wdata);
                  end
               end
            end else if (sbEnable) begin
               checkOutput("busy_stable_we", 32'(mem_we_o), 32'(cur.we));
               checkOutput("busy_stable_addr", mem_addr_o, cur.addr);
               checkOutput("busy_stable_wdata", mem_wdata_o, cur.wdata);
            end
            if (ackDelay >= 0 && busy == ackDelay + 1) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = memData(mem_addr_o);
            end else begin
               mem_ack_i   = 1'b0;
               mem_rdata_i = $urandom;
            end
         end else begin
            if (busy != 0) lastBusyLen = busy;
            busy        = 0;
            mem_ack_i   = strayAck;
            mem_rdata_i = $urandom;
         end
      end
   end

   // Read-data scoreboard: pops on each ready pulse, otherwise rdata must hold.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         lastIf = '0;
         lastDm = '0;
      end else if (sbEnable) begin
         if (if_ready_o) begin
            if (ifQ.size() == 0) begin
               checkOutput("if_unexpected_ready", 32'(if_ready_o), 0);
            end else begin
               monIf = ifQ.pop_front();
               checkOutput("if_rdata", if_rdata_o, monIf);
               lastIf = monIf;
            end
         end else begin
            checkOutput("if_rdata_hold", if_rdata_o, lastIf);
         end
         if (dm_ready_o) begin
            if (dmQ.size() == 0) begin
               checkOutput("dm_unexpected_ready", 32'(dm_ready_o), 0);
            end else begin
               monDm = dmQ.pop_front();
               if (monDm.we) begin
                  checkOutput("dm_rdata_after_write", dm_rdata_o, lastDm);
               end else begin
                  checkOutput("dm_rdata", dm_rdata_o, monDm.rdata);
                  lastDm = monDm.rdata;
               end
            end
         end else begin
            checkOutput("dm_rdata_hold", dm_rdata_o, lastDm);
         end
      end
   end

   task automatic ifRead(input logic [31:0] addr, input logic [31:0] expRdata, output int readyCycle);
      int waited;
      int rc;
      waited = 0;
      rc     = -1;
      ifQ.push_back(expRdata);
      if_addr_i = addr;
      if_req_i  = 1'b1;
      while (rc < 0 && waited < 60) begin
         @(posedge clk_i);
         #1;
         waited++;
         if (if_ready_o) rc = cycleCount;
      end
      if (rc < 0) checkOutput("if_ready_timeout", 32'(if_ready_o), 1);
      if_req_i   = 1'b0;
      readyCycle = rc;
   endtask

   // Holds dm_req_i high across n back-to-back transfers.
   task automatic dmAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expRdata, input int n, output int readyCycle);
      dm_exp_t e;
      int      waited;
      int      done;
      int      rc;
      waited = 0;
      done   = 0;
      rc     = -1;
      for (int i = 0; i < n; i++) begin
         e.we    = we;
         e.rdata = expRdata;
         dmQ.push_back(e);
      end
      dm_we_i    = we;
      dm_addr_i  = addr;
      dm_wdata_i = wdata;
      dm_req_i   = 1'b1;
      while (done < n && waited < 60 * n) begin
         @(posedge clk_i);
         #1;
         waited++;
         if (dm_ready_o) begin
            done++;
            rc = cycleCount;
         end
      end
      if (done < n) checkOutput("dm_ready_timeout", done, n);
      dm_req_i   = 1'b0;
      readyCycle = rc;
   endtask

   // Directed scenarios, each leaving the arbiter idle for the next.
   task automatic applyStimulus();
      int rcIf;
      int rcDm;

      rst_i      = 1'b0;
      if_req_i   = 1'b0;
      if_addr_i  = '0;
      dm_req_i   = 1'b0;
      dm_we_i    = 1'b0;
      dm_addr_i  = '0;
      dm_wdata_i = '0;
      idleCycles(3);
      checkOutput("rst_mem_req", 32'(mem_req_o), 0);
      checkOutput("rst_mem_we", 32'(mem_we_o), 0);
      checkOutput("rst_mem_addr", mem_addr_o, 0);
      checkOutput("rst_mem_wdata", mem_wdata_o, 0);
      checkOutput("rst_if_ready", 32'(if_ready_o), 0);
      checkOutput("rst_dm_ready", 32'(dm_ready_o), 0);
      checkOutput("rst_if_rdata", if_rdata_o, 0);
      checkOutput("rst_dm_rdata", dm_rdata_o, 0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt_o), 0);
      checkOutput("rst_err", 32'(err_o), 0);
      rst_i = 1'b1;
      idleCycles(1);

      // Lone zero-wait fetch: exact cycle timing.
      ackDelay = 0;
      ifQ.push_back(32'h8C01_0000);
      pushGrant(1'b0, 32'h10, '0);
      if_addr_i = 32'h10;
      if_req_i  = 1'b1;
      #2;
      checkOutput("t20_c0_mem_req", 32'(mem_req_o), 0);
      checkOutput("t20_c0_stall", 32'(stall_o), 1);
      idleCycles(1);
      checkOutput("t20_c1_mem_req", 32'(mem_req_o), 1);
      checkOutput("t20_c1_if_ready", 32'(if_ready_o), 0);
      idleCycles(1);
      checkOutput("t20_c2_if_ready", 32'(if_ready_o), 1);
      checkOutput("t20_c2_if_rdata", if_rdata_o, 32'h8C01_0000);
      checkOutput("t20_c2_stall_cnt", 32'(stall_cnt_o), 2);
      if_req_i = 1'b0;
      idleCycles(1);
      checkOutput("t20_c3_if_ready", 32'(if_ready_o), 0);

      // Simultaneous DM write and IF read with one wait state each.
      ackDelay = 1;
      pushGrant(1'b1, 32'h04, 32'h5);
      pushGrant(1'b0, 32'h20, '0);
      fork
         dmAccess(1'b1, 32'h04, 32'h5, '0, 1, rcDm);
         ifRead(32'h20, memData(32'h20), rcIf);
      join
      checkOutput("t21_if_after_dm", rcIf - rcDm, 3);
      idleCycles(2);

      // DM requesting continuously must not starve IF.
      ackDelay = 0;
      pushGrant(1'b0, 32'h100, '0);
      pushGrant(1'b0, 32'h200, '0);
      pushGrant(1'b0, 32'h100, '0);
      fork
         dmAccess(1'b0, 32'h100, 32'hDEAD_BEEF, memData(32'h100), 2, rcDm);
         ifRead(32'h200, memData(32'h200), rcIf);
      join
      checkOutput("t22_if_before_last_dm", 32'(rcIf < rcDm), 1);
      idleCycles(2);

      // Ack on the very cycle the timeout would fire is a normal completion.
      ackDelay = TIMEOUT - 1;
      pushGrant(1'b0, 32'h50, '0);
      dmAccess(1'b0, 32'h50, '0, memData(32'h50), 1, rcDm);
      idleCycles(1);
      checkOutput("t14_busy_len", lastBusyLen, TIMEOUT);
      checkOutput("t14_err", 32'(err_o), 0);

      // No ack at all: timeout returns zero data and sets the sticky error.
      ackDelay = -1;
      pushGrant(1'b0, 32'h40, '0);
      dmAccess(1'b0, 32'h40, '0, '0, 1, rcDm);
      idleCycles(1);
      checkOutput("t23_busy_len", lastBusyLen, TIMEOUT);
      checkOutput("t23_err", 32'(err_o), 1);
      checkOutput("t23_mem_req", 32'(mem_req_o), 0);
      ackDelay = 0;
      pushGrant(1'b0, 32'h30, '0);
      ifRead(32'h30, memData(32'h30), rcIf);
      idleCycles(1);
      checkOutput("t23_err_sticky", 32'(err_o), 1);

      // Stray ack while idle must be ignored.
      strayAck = 1'b1;
      idleCycles(3);
      checkOutput("t15_mem_req", 32'(mem_req_o), 0);
      checkOutput("t15_if_ready", 32'(if_ready_o), 0);
      checkOutput("t15_dm_ready", 32'(dm_ready_o), 0);
      strayAck = 1'b0;
      idleCycles(2);

      // Reset in the middle of a fetch aborts it without a ready pulse.
      ackDelay = -1;
      pushGrant(1'b0, 32'h60, '0);
      if_addr_i = 32'h60;
      if_req_i  = 1'b1;
      idleCycles(1);
      checkOutput("t24_busy_mem_req", 32'(mem_req_o), 1);
      idleCycles(1);
      rst_i = 1'b0;
      #1;
      checkOutput("t24_mem_req", 32'(mem_req_o), 0);
      checkOutput("t24_if_ready", 32'(if_ready_o), 0);
      checkOutput("t24_mem_addr", mem_addr_o, 0);
      checkOutput("t24_if_rdata", if_rdata_o, 0);
      checkOutput("t24_dm_rdata", dm_rdata_o, 0);
      checkOutput("t24_stall_cnt", 32'(stall_cnt_o), 0);
      checkOutput("t24_err", 32'(err_o), 0);
      if_req_i = 1'b0;
      idleCycles(2);
      checkOutput("t24_no_ready", 32'(if_ready_o), 0);
      rst_i = 1'b1;
      idleCycles(1);
      ackDelay = 0;
      pushGrant(1'b0, 32'h70, '0);
      ifRead(32'h70, memData(32'h70), rcIf);
      idleCycles(2);

      checkOutput("sb_if_queue_empty", ifQ.size(), 0);
      checkOutput("sb_dm_queue_empty", dmQ.size(), 0);
      checkOutput("sb_grant_queue_empty", grantQ.size(), 0);

      // Both requesters held high keep stall_o asserted; counter must saturate.
      sbEnable = 1'b0;
      rst_i    = 1'b0;
      idleCycles(1);
      rst_i     = 1'b1;
      if_addr_i = 32'h80;
      if_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h90;
      dm_req_i  = 1'b1;
      repeat (1000) @(posedge clk_i);
      #1;
      checkOutput("t25_stall", 32'(stall_o), 1);
      checkOutput("t25_cnt_1000", 32'(stall_cnt_o), 1000);
      repeat (69000) @(posedge clk_i);
      #1;
      checkOutput("t25_cnt_saturated", 32'(stall_cnt_o), 65535);
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
